rc_cmp_width_ctrl: RTL

RC_CMP_WIDTH_CTRL -- requirements
Module: rc_cmp_width_ctrl

---
 rtl/rc_cmp_width_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/rc_cmp_width_ctrl.sv
// RC charge-time measurement controller: discharges the RC network, then charges it
// and counts clk cycles until the comparator trips, reporting the count or a timeout.
module rc_cmp_width_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             stim,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] width,
    output logic             timed_out
);

    typedef enum logic [1:0] {
        IDLE,
        DISCH,
        MEAS,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL      = CNT_W'(TIMEOUT);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] width_nx;
    logic             to_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            width     <= '0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            width     <= width_nx;
            timed_out <= to_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        width_nx = width;
        to_nx    = timed_out;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) state_nx = DISCH;
            end
            DISCH: begin
                // Settling takes priority over a timeout landing on the same edge.
                if (cnt >= SETTLE_LAST && !cmp_in) begin
                    state_nx = MEAS;
                    cnt_nx   = '0;
                end else if (cnt >= TO_LAST) begin
                    state_nx = REPORT;
                    width_nx = TO_VAL;
                    to_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            MEAS: begin
                if (cmp_in) begin
                    state_nx = REPORT;
                    width_nx = cnt;
                    to_nx    = 1'b0;
                end else if (cnt >= TO_LAST) begin
                    state_nx = REPORT;
                    width_nx = TO_VAL;
                    to_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            REPORT: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode the state register, so reset clears them without waiting for clk.
    assign busy = (state != IDLE);
    assign stim = (state == MEAS);
    assign done = (state == REPORT);

endmodule
